// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
// Shares the single dcache port between the pipeline memory stage and one
// secondary requester (debug/DMA). While the secondary owns the port the
// pipeline is stalled, and the pipeline load data in flight at takeover is
// held and returned in RESTORE.
// Optional feature: define DCACHE_ARB_STARVE_EN to force a grant after
// STARVE_LIMIT consecutive busy-pipeline cycles; otherwise the secondary is
// granted only on idle pipeline cycles.
module dcache_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    input  logic [3:0]  cpu_we,
    input  logic        cpu_re,
    output logic [31:0] cpu_dout,
    output logic        cpu_stall,
    input  logic        sec_req,
    input  logic [31:0] sec_addr,
    input  logic [31:0] sec_din,
    input  logic [3:0]  sec_we,
    output logic        sec_gnt,
    output logic        sec_rvalid,
    output logic [31:0] sec_dout,
    input  logic [31:0] dcache_dout,
    input  logic        dcache_stall,
    output logic [31:0] dcache_addr,
    output logic [31:0] dcache_din,
    output logic [3:0]  dcache_we,
    output logic        dcache_re
);

    typedef enum logic [1:0] {
        IDLE,
        SEC_ISSUE,
        SEC_RESP,
        RESTORE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] cpu_hold;
    logic        cpu_active;
    logic        starve_hit;
    logic        grant_now;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
        $error("dcache_port_arbiter: STARVE_LIMIT must be in 1..255");
    end

    assign cpu_active = cpu_re || (cpu_we != '0);
    assign grant_now  = (state == IDLE) && sec_req && !dcache_stall &&
                        (!cpu_active || starve_hit);

`ifdef DCACHE_ARB_STARVE_EN
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;

    // Count busy-pipeline cycles seen by a waiting secondary request, saturating.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!dcache_stall) begin
            if (!sec_req || grant_now) begin
                starve_cnt <= '0;
            end else if ((state == IDLE) && cpu_active && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

    assign starve_hit = (starve_cnt == STARVE_MAX);
`else
    assign starve_hit = 1'b0;
`endif

    // State register; dcache_stall freezing is folded into state_next.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the cache-side / pipeline-side output muxes.
    always_comb begin
        state_next  = state;
        dcache_addr = cpu_addr;
        dcache_din  = cpu_din;
        dcache_we   = cpu_we;
        dcache_re   = cpu_re;
        cpu_dout    = dcache_dout;
        cpu_stall   = dcache_stall;
        sec_gnt     = 1'b0;

        unique case (state)
            IDLE: begin
                if (grant_now) begin
                    state_next = SEC_ISSUE;
                end
            end
            SEC_ISSUE: begin
                dcache_addr = sec_addr;
                dcache_din  = sec_din;
                dcache_we   = sec_we;
                dcache_re   = (sec_we == '0);
                cpu_stall   = 1'b1;
                // The grant pulses on the cycle the cache actually accepts the access.
                sec_gnt     = !dcache_stall;
                if (!dcache_stall) begin
                    state_next = (sec_we == '0) ? SEC_RESP : RESTORE;
                end
            end
            SEC_RESP: begin
                dcache_addr = sec_addr;
                dcache_din  = sec_din;
                dcache_we   = '0;
                dcache_re   = 1'b0;
                cpu_stall   = 1'b1;
                if (!dcache_stall) begin
                    state_next = RESTORE;
                end
            end
            RESTORE: begin
                cpu_dout = cpu_hold;
                if (!dcache_stall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (!reset) begin
            dcache_we = '0;
            dcache_re = 1'b0;
        end
    end

    // Capture the in-flight pipeline load at takeover and the secondary read return.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_hold   <= '0;
            sec_dout   <= '0;
            sec_rvalid <= 1'b0;
        end else begin
            sec_rvalid <= (state == SEC_RESP) && !dcache_stall;
            if (!dcache_stall) begin
                if (state == SEC_ISSUE) begin
                    cpu_hold <= dcache_dout;
                end
                if (state == SEC_RESP) begin
                    sec_dout <= dcache_dout;
                end
            end
        end
    end

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Shares the single data-cache port between the pipeline's memory stage and one secondary requester, such as a debug or DMA engine. The block sits between the stage-3 memory logic and the dcache, and muxes address, write-enable, read-enable and write data to the cache. It stalls the pipeline while the secondary owns the port, and preserves the pipeline's in-flight load data across the takeover.

## Interface
- STARVE_LIMIT, 8: consecutive pipeline-busy cycles a pending secondary request waits before a forced grant; range 1–255.
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- cpu_addr  in  32  pipeline byte address (stage-2 ALU result).
- cpu_din  in  32  pipeline store data.
- cpu_we  in  4  pipeline byte write enables.
- cpu_re  in  1  pipeline load request.
- cpu_dout  out  32  load data returned to stage 3.
- cpu_stall  out  1  pipeline must hold stages 2/3.
- sec_req  in  1  secondary request, level.
- sec_addr  in  32  secondary address; stable while sec_req is high and sec_gnt has not yet pulsed.
- sec_din  in  32  secondary store data; same stability rule as sec_addr.
- sec_we  in  4  secondary byte write enables; 0 means read; same stability rule as sec_addr.
- sec_gnt  out  1  one-cycle pulse; the request is issued to the cache this cycle.
- sec_rvalid  out  1  one-cycle pulse; sec_dout is valid.
- sec_dout  out  32  secondary read data, registered.
- dcache_dout  in  32  cache read data; valid one cycle after the read issue.
- dcache_stall  in  1  cache busy (miss/refill); all inputs to the cache must hold.
- dcache_addr  out  32  cache address.
- dcache_din  out  32  cache write data.
- dcache_we  out  4  cache byte write enables.
- dcache_re  out  1  cache read enable.

## Operation

**States:** IDLE, SEC_ISSUE, SEC_RESP, RESTORE.

**IDLE**
- Cache driven from the cpu_* inputs.
- cpu_dout = dcache_dout.
- cpu_stall = 0.
- Go to SEC_ISSUE next cycle when sec_req && !dcache_stall && (cpu_re==0 && cpu_we==0, or starve_cnt==STARVE_LIMIT).

**SEC_ISSUE**
- Cache driven from the sec_* inputs.
- sec_gnt = 1, cpu_stall = 1.
- cpu_hold <= dcache_dout: captures the pipeline load issued in the previous cycle.
- Next state is SEC_RESP if sec_we==0, otherwise RESTORE.

**SEC_RESP**
- dcache_re = 0, dcache_we = 0.
- cpu_stall = 1.
- sec_dout <= dcache_dout, sec_rvalid <= 1.
- Next state is RESTORE.

**RESTORE**
- Cache driven from the cpu_* inputs, which replays the stalled pipeline access.
- cpu_stall = 0.
- cpu_dout = cpu_hold.
- Next state is IDLE. sec_req is not sampled in this state.

**starve_cnt (8-bit)**
- In IDLE: increments while sec_req is high and the cpu port is active.
- Saturates at STARVE_LIMIT.
- Clears on entry to SEC_ISSUE, and whenever sec_req is low.

**dcache_stall high**
- The state register, starve_cnt and the capture registers freeze.
- Cache outputs hold the current state's selection.
- cpu_stall is forced to 1 in every state.
- No new grant is made.

**sec_rvalid:** the register is cleared every cycle it is not being set.

**Simultaneous events:** when sec_req rises in the same cycle the cpu port is idle, the grant wins. The pipeline access that would arrive next cycle sees cpu_stall.

## Timing
- **Reset values:** state = IDLE; starve_cnt = 0; cpu_hold = 0; sec_dout = 0; sec_rvalid = 0; sec_gnt = 0; cpu_stall = 0.
- **During reset:** dcache_we = 0 and dcache_re = 0.
- **Reset mid-transaction:** the secondary access is dropped with no sec_rvalid. The pipeline is not stalled in the following cycle.
- **Secondary read latency:** sec_gnt in cycle G; sec_rvalid in cycle G+2.
- **Secondary write:** sec_gnt in cycle G; the pipeline resumes in cycle G+1.
- **Pipeline cost of a secondary read:** two stall cycles (G, G+1), then RESTORE in cycle G+2.
- **Pipeline cost of a secondary write:** one stall cycle.
- **Combinational paths:**
  - the cache-side mux and cpu_dout depend only on state plus inputs;
  - cpu_stall depends on state and dcache_stall;
  - there is no path from sec_req to cpu_stall.
- **Back-to-back secondary requests:** minimum spacing is RESTORE + IDLE, so at most one grant every 3 (write) or 4 (read) cycles.

## Configuration
- **DCACHE_ARB_STARVE_EN defined:** the starve_cnt forced grant is active, as described under Operation.
- **Undefined:** starve_cnt is removed. The secondary is granted only in IDLE cycles with cpu_re==0 and cpu_we==0; a continuously busy pipeline starves it indefinitely. The STARVE_LIMIT parameter is ignored.

## Test plan
- Idle pipeline; secondary read of 0x100 holding 0xDEADBEEF:
  - sec_gnt in cycle 1;
  - sec_rvalid with sec_dout = 0xDEADBEEF in cycle 3;
  - cpu_stall high in cycles 1–2 only.
- Pipeline load to 0x40 (data 0x12345678) issued in the same cycle the secondary is force-granted: cpu_dout = 0x12345678 in RESTORE, and the stalled cpu access is replayed to the cache.
- Macro defined, STARVE_LIMIT = 4, pipeline issues loads every cycle, sec_req high at cycle 0:
  - sec_gnt in cycle 5;
  - cpu_stall high in cycles 5–6.
- Same stimulus with the macro undefined: sec_gnt is never asserted over 100 cycles; cpu_stall stays 0.
- Secondary write of 0xA5A5A5A5 to 0x200 with sec_we = 4'hF: dcache_we = 4'hF for exactly one cycle; no sec_rvalid; one stall cycle.
- dcache_stall high for 3 cycles during SEC_ISSUE: dcache_addr and dcache_we hold the secondary values, and sec_rvalid is delayed by 3 cycles.
- Reset asserted during SEC_RESP: the next cycle is IDLE with sec_rvalid = 0 and cpu_stall = 0.
